// File: rtl/recv_module_pkg.sv
// rtl/recv_module_pkg.sv - packet format defaults, FSM state type and error flag positions for recv_module
package recv_module_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int PORT_NUB_DEF   = 4;
  localparam int LENGTH_MAX_DEF = 16;
  localparam int PRIORITY_DEF   = 4;
  localparam int CNT_WIDTH_DEF  = 16;

  // Bit positions inside err_flags: {data,dest,length,framing}
  localparam int ERR_FRAME = 0;
  localparam int ERR_LEN   = 1;
  localparam int ERR_DEST  = 2;
  localparam int ERR_DATA  = 3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

endpackage

// File: rtl/recv_module_lfsr_ready_gen.sv
// rtl/recv_module_lfsr_ready_gen.sv - 16-bit Galois LFSR whose bit 0 gates ready to emulate output stalls
module lfsr_ready_gen
  import recv_module_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic ready_bit
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign ready_bit = lfsr_q[0];

endmodule

// File: rtl/recv_module.sv
// rtl/recv_module.sv - per-port receive checker; RECV_BACKPRESSURE_EN enables LFSR-driven ready stalls
module recv_module
  import recv_module_pkg::*;
#(
  parameter int rx_port    = 0,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PORT_NUB   = PORT_NUB_DEF,
  parameter int LENGTH_MAX = LENGTH_MAX_DEF,
  parameter int PRIORITY   = PRIORITY_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  localparam int WS = $clog2(PORT_NUB),
  localparam int WL = $clog2(LENGTH_MAX),
  localparam int WP = $clog2(PRIORITY)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_sop,
  input  logic                  rd_eop,
  input  logic                  rd_vld,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ready,
  input  logic                  clr,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [3:0]            err_flags,
  output logic [WS-1:0]         last_src,
  output logic [WL-1:0]         last_length
);

  localparam int BW = WL + 1;

  state_t               state_q, state_d;
  logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [WS-1:0]        src_q, src_d;
  logic [WL-1:0]        len_q, len_d;
  logic [3:0]           pkt_err_q, pkt_err_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]           err_flags_q, err_flags_d;
  logic [WS-1:0]        last_src_q, last_src_d;
  logic [WL-1:0]        last_length_q, last_length_d;
  logic                 ready_q, ready_d;

  logic                  accept, hdr_take, close, close_bad;
  logic [3:0]            new_err, beat_err;
  logic [WL-1:0]         hdr_len;
  logic [WS-1:0]         hdr_src, hdr_dest;
  logic [DATA_WIDTH-1:0] exp_data;

  assign hdr_len  = rd_data[WL-1:0];
  assign hdr_dest = rd_data[WL+WP +: WS];
  assign hdr_src  = rd_data[WL+WP+WS +: WS];
  assign exp_data = {src_q, {(DATA_WIDTH-WS-BW){1'b0}}, beat_cnt_q};

`ifdef RECV_BACKPRESSURE_EN
  logic lfsr_bit;
  lfsr_ready_gen u_lfsr_ready_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .ready_bit (lfsr_bit)
  );
  assign ready = ready_q & lfsr_bit;
`else
  assign ready = ready_q;
`endif

  assign accept = rd_vld & ready;

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    src_d         = src_q;
    len_d         = len_q;
    pkt_err_d     = pkt_err_q;
    pkt_cnt_d     = pkt_cnt_q;
    err_cnt_d     = err_cnt_q;
    last_src_d    = last_src_q;
    last_length_d = last_length_q;
    ready_d       = 1'b1;
    new_err       = 4'b0000;
    beat_err      = 4'b0000;
    hdr_take      = 1'b0;
    close         = 1'b0;
    close_bad     = 1'b0;

    if (accept) begin
      if (state_q == ST_IDLE) begin
        if (rd_sop && !rd_eop) begin
          hdr_take = 1'b1;
        end else begin
          new_err[ERR_FRAME] = 1'b1;
          close              = 1'b1;
          close_bad          = 1'b1;
        end
      end else if (rd_sop) begin
        // An sop inside a packet kills the open packet; the new header is kept unless it also ends
        new_err[ERR_FRAME] = 1'b1;
        close              = 1'b1;
        close_bad          = 1'b1;
        hdr_take           = !rd_eop;
        state_d            = ST_IDLE;
      end else begin
        if (beat_cnt_q >= {1'b0, len_q}) beat_err[ERR_LEN] = 1'b1;
        else if (rd_data != exp_data)    beat_err[ERR_DATA] = 1'b1;
        if (rd_eop && (beat_cnt_q + BW'(1) != {1'b0, len_q})) beat_err[ERR_LEN] = 1'b1;
        new_err = beat_err;
        if (rd_eop) begin
          close     = 1'b1;
          close_bad = |(pkt_err_q | beat_err);
          state_d   = ST_IDLE;
        end else begin
          pkt_err_d = pkt_err_q | beat_err;
          if (beat_cnt_q != {BW{1'b1}}) beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
    end

    if (hdr_take) begin
      state_d           = ST_DATA;
      beat_cnt_d        = '0;
      src_d             = hdr_src;
      len_d             = hdr_len;
      pkt_err_d         = 4'b0000;
      pkt_err_d[ERR_DEST] = (hdr_dest != WS'(rx_port));
      new_err           = new_err | pkt_err_d;
      last_src_d        = hdr_src;
      last_length_d     = hdr_len;
    end

    done_d = close;
    if (close) begin
      if (close_bad) begin
        if (err_cnt_q != {CNT_WIDTH{1'b1}}) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end else begin
        if (pkt_cnt_q != {CNT_WIDTH{1'b1}}) pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
      end
    end

    err_flags_d = err_flags_q | new_err;
    if (clr) begin
      pkt_cnt_d   = '0;
      err_cnt_d   = '0;
      err_flags_d = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      beat_cnt_q    <= '0;
      src_q         <= '0;
      len_q         <= '0;
      pkt_err_q     <= 4'b0000;
      done_q        <= 1'b0;
      pkt_cnt_q     <= '0;
      err_cnt_q     <= '0;
      err_flags_q   <= 4'b0000;
      last_src_q    <= '0;
      last_length_q <= '0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      src_q         <= src_d;
      len_q         <= len_d;
      pkt_err_q     <= pkt_err_d;
      done_q        <= done_d;
      pkt_cnt_q     <= pkt_cnt_d;
      err_cnt_q     <= err_cnt_d;
      err_flags_q   <= err_flags_d;
      last_src_q    <= last_src_d;
      last_length_q <= last_length_d;
      ready_q       <= ready_d;
    end
  end

  assign done        = done_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign err_flags   = err_flags_q;
  assign last_src    = last_src_q;
  assign last_length = last_length_q;

endmodule

// File: tb/tb_recv_module.sv
// tb/tb_recv_module.sv - scoreboard bench for recv_module at rx_port=2 (honours RECV_BACKPRESSURE_EN)
module tb_recv_module;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_sop = 1'b0, rd_eop = 1'b0, rd_vld = 1'b0, clr = 1'b0;
  logic [31:0] rd_data = '0;
  logic        ready, done;
  logic [15:0] pkt_cnt, err_cnt;
  logic [3:0]  err_flags;
  logic [1:0]  last_src;
  logic [3:0]  last_length;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         pc;
    int         ec;
    logic [3:0] fl;
    int         src;
    int         len;
  } exp_t;
  exp_t sbq[$];

  recv_module #(.rx_port(2)) dut (
    .clk(clk), .rst_n(rst_n), .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld),
    .rd_data(rd_data), .ready(ready), .clr(clr), .done(done), .pkt_cnt(pkt_cnt),
    .err_cnt(err_cnt), .err_flags(err_flags), .last_src(last_src), .last_length(last_length)
  );

  always #2 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input int src, input int dest, input int len);
    return 32'(len) | (32'(dest) << 6) | (32'(src) << 8);
  endfunction

  function automatic logic [31:0] pay(input int src, input int k);
    return (32'(src) << 30) | 32'(k);
  endfunction

  task automatic push(input int pc, input int ec, input logic [3:0] fl, input int src, input int len);
    exp_t e;
    e.pc = pc; e.ec = ec; e.fl = fl; e.src = src; e.len = len;
    sbq.push_back(e);
  endtask

  task automatic beat(input logic s, input logic e, input logic [31:0] d, input logic c = 1'b0);
    int n = 0;
    @(negedge clk);
    rd_sop = s; rd_eop = e; rd_data = d; rd_vld = 1'b1; clr = c;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0; clr = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic good_pkt(input int src, input int len);
    beat(1'b1, 1'b0, hdr(src, 2, len));
    for (int k = 0; k < len; k++) beat(1'b0, k == len - 1, pay(src, k));
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("pkt_cnt", int'(pkt_cnt), e.pc);
        chk("err_cnt", int'(err_cnt), e.ec);
        chk("err_flags", int'(err_flags), int'(e.fl));
        chk("last_src", int'(last_src), e.src);
        chk("last_length", int'(last_length), e.len);
      end
    end
  end

  initial begin
    int src, len;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pkt_cnt", int'(pkt_cnt), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_flags", int'(err_flags), 0);
    chk("rst_last", int'({last_src, last_length}), 0);
    rst_n = 1'b1;
`ifndef RECV_BACKPRESSURE_EN
    @(negedge clk);
    chk("ready_after_rst", int'(ready), 1);
`endif

    // 1: good packet
    push(1, 0, 4'b0000, 1, 4);
    good_pkt(1, 4);

    // 2: payload beat 2 corrupted
    do_clr();
    push(0, 1, 4'b1000, 1, 4);
    beat(1'b1, 1'b0, hdr(1, 2, 4));
    for (int k = 0; k < 4; k++) beat(1'b0, k == 3, pay(1, k) ^ (k == 2 ? 32'h1 : 32'h0));

    // 3: eop on 3rd payload beat of a len=4 packet
    do_clr();
    push(0, 1, 4'b0010, 1, 4);
    beat(1'b1, 1'b0, hdr(1, 2, 4));
    for (int k = 0; k < 3; k++) beat(1'b0, k == 2, pay(1, k));

    // 4: sop mid-packet, then the new 2-beat packet completes good
    do_clr();
    beat(1'b1, 1'b0, hdr(1, 2, 4));
    beat(1'b0, 1'b0, pay(1, 0));
    beat(1'b0, 1'b0, pay(1, 1));
    push(0, 1, 4'b0001, 3, 2);
    beat(1'b1, 1'b0, hdr(3, 2, 2));
    push(1, 1, 4'b0001, 3, 2);
    beat(1'b0, 1'b0, pay(3, 0));
    beat(1'b0, 1'b1, pay(3, 1));

    // 5: wrong dest, then clr the next cycle
    do_clr();
    push(0, 1, 4'b0100, 0, 1);
    beat(1'b1, 1'b0, hdr(0, 1, 1));
    beat(1'b0, 1'b1, pay(0, 0));
    do_clr();
    @(negedge clk);
    chk("clr_pkt_cnt", int'(pkt_cnt), 0);
    chk("clr_err_cnt", int'(err_cnt), 0);
    chk("clr_flags", int'(err_flags), 0);

    // Framing in IDLE: stray beat, then sop&&eop on one beat (header not latched)
    push(0, 1, 4'b0001, 0, 1);
    beat(1'b0, 1'b0, pay(0, 0));
    push(0, 2, 4'b0001, 0, 1);
    beat(1'b1, 1'b1, hdr(1, 2, 1));

    // Overrun: len=2 but three payload beats
    do_clr();
    push(0, 1, 4'b0010, 1, 2);
    beat(1'b1, 1'b0, hdr(1, 2, 2));
    for (int k = 0; k < 3; k++) beat(1'b0, k == 2, pay(1, k));

    // clr on the closing beat wins over the increment
    do_clr();
    push(0, 0, 4'b0000, 2, 1);
    beat(1'b1, 1'b0, hdr(2, 2, 1));
    beat(1'b0, 1'b1, pay(2, 0), 1'b1);

    // 6: many random good packets
    do_clr();
    for (int i = 0; i < 1000; i++) begin
      src = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 15));
      push(i + 1, 0, 4'b0000, src, len);
      good_pkt(src, len);
    end

    // Reset mid-packet: partial packet dropped, FSM back in IDLE
    beat(1'b1, 1'b0, hdr(1, 2, 3));
    beat(1'b0, 1'b0, pay(1, 0));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", int'(ready), 0);
    chk("midrst_pkt_cnt", int'(pkt_cnt), 0);
    chk("midrst_err_cnt", int'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push(1, 0, 4'b0000, 3, 2);
    good_pkt(3, 2);

    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
